// File: rtl/capture_sequencer_pkg.sv
// rtl/capture_sequencer_pkg.sv - shared types and constants for the capture sequencer
// Contents: state_t FSM encoding, cmd_t layout of cmd_in.data, START_CMD/STOP_CMD codes.
package capture_sequencer_pkg;

  localparam int CS_BANK_W  = 2;
  localparam int CS_COUNT_W = 16;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CONFIG    = 4'd1,
    ARM       = 4'd2,
    WAIT_TRIG = 4'd3,
    CAPTURE   = 4'd4,
    READOUT   = 4'd5
  } state_t;

  // cmd_in.data = {repeat[31:16], rsvd, banking_mode[BANK_W+1:2], use_aux[1], arm[0]}
  typedef struct packed {
    logic [CS_COUNT_W-1:0]                  repeat_count;
    logic [32-CS_COUNT_W-CS_BANK_W-3:0]     rsvd;
    logic [CS_BANK_W-1:0]                   banking_mode;
    logic                                   use_aux;
    logic                                   arm;
  } cmd_t;

  localparam logic [1:0] START_CMD = 2'b10;
  localparam logic [1:0] STOP_CMD  = 2'b01;

endpackage

// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - stream handshake interface used on the sequencer ports
// Signals: data[DATA_W-1:0], valid, last (source -> sink), ready (sink -> source).
// Modports: master (source side), slave (sink side).
interface axis_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/capture_sequencer_edge_detect.sv
// rtl/capture_sequencer_edge_detect.sv - registered rising-edge detector
// Ports: clk, rst_n (async active-low), din (level in), rise (registered one-cycle pulse).
module capture_sequencer_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic din_q, din_d;
  logic rise_q, rise_d;

  always_comb begin
    din_d  = din;
    rise_d = din & ~din_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      din_q  <= din_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - repeated capture/readout sequencer for the sparse sample buffer
// Ports: clk, reset_n (async active-low); cmd_in (slave, 32b command);
//   buffer_config (master, banking mode); buffer_start_stop (master, {start,stop});
//   capture_done, dma_last_ok, start_aux (inputs); trigger_out, busy, status (registered outputs).
// Optional: CAPTURE_SEQUENCER_TIMEOUT_EN builds the capture timeout counter.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int BANK_W         = CS_BANK_W,
  parameter int COUNT_W        = CS_COUNT_W,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic   clk,
  input  logic   reset_n,
  axis_if.slave  cmd_in,
  axis_if.master buffer_config,
  axis_if.master buffer_start_stop,
  input  logic   capture_done,
  input  logic   dma_last_ok,
  input  logic   start_aux,
  output logic   trigger_out,
  output logic   busy,
  output logic [31:0] status
);
  state_t             state_q, state_d;
  logic [COUNT_W-1:0] repeat_q, repeat_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic               use_aux_q, use_aux_d;
  logic [COUNT_W-1:0] captures_q, captures_d;
  logic               tmo_flag_q, tmo_flag_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               ss_valid_q, ss_valid_d;
  logic [1:0]         ss_data_q, ss_data_d;
  logic               trigger_q, trigger_d;
  logic               busy_q, busy_d;

  cmd_t               cmd;
  logic               arm_cmd, abort_cmd;
  logic               aux_rise;
  logic               tmo_hit;
  logic [COUNT_W-1:0] captures_inc;
  logic               unused_bits;

  assign cmd       = cmd_t'(cmd_in.data);
  assign arm_cmd   = cmd_in.valid & cmd.arm;
  assign abort_cmd = cmd_in.valid & ~cmd.arm;
  assign unused_bits = ^{cmd.rsvd, cmd_in.last};

  // Counter saturates rather than wrapping so software never sees a drop.
  assign captures_inc = (captures_q == '1) ? captures_q : captures_q + 1'b1;

  capture_sequencer_edge_detect u_edge_detect (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (start_aux),
    .rise  (aux_rise)
  );

`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Held at zero outside CAPTURE, so every CAPTURE entry starts from zero.
  always_comb begin
    tmo_cnt_d = (state_q == CAPTURE) ? tmo_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    repeat_d    = repeat_q;
    bank_d      = bank_q;
    use_aux_d   = use_aux_q;
    captures_d  = captures_q;
    tmo_flag_d  = tmo_flag_q;
    cfg_valid_d = cfg_valid_q;
    ss_valid_d  = ss_valid_q;
    ss_data_d   = ss_data_q;
    trigger_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_cmd) begin
          repeat_d    = cmd.repeat_count;
          bank_d      = cmd.banking_mode;
          use_aux_d   = cmd.use_aux;
          captures_d  = '0;
          tmo_flag_d  = 1'b0;
          cfg_valid_d = 1'b1;
          state_d     = CONFIG;
        end
      end
      CONFIG: begin
        if (abort_cmd) begin
          cfg_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (cfg_valid_q && buffer_config.ready) begin
          cfg_valid_d = 1'b0;
          state_d     = ARM;
        end
      end
      ARM: begin
        if (abort_cmd) begin
          ss_valid_d = 1'b0;
          state_d    = IDLE;
        end else if (use_aux_q) begin
          state_d = WAIT_TRIG;
        end else if (ss_valid_q && buffer_start_stop.ready) begin
          ss_valid_d = 1'b0;
          state_d    = CAPTURE;
        end else begin
          ss_valid_d = 1'b1;
          ss_data_d  = START_CMD;
        end
      end
      WAIT_TRIG: begin
        if (abort_cmd) begin
          state_d = IDLE;
        end else if (aux_rise) begin
          trigger_d = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        // A stop already on the bus must complete before leaving.
        if (ss_valid_q) begin
          if (buffer_start_stop.ready) begin
            ss_valid_d = 1'b0;
            state_d    = READOUT;
          end
        end else if (capture_done) begin
          state_d = READOUT;
        end else if (abort_cmd) begin
          ss_valid_d = 1'b1;
          ss_data_d  = STOP_CMD;
        end else if (tmo_hit) begin
          ss_valid_d = 1'b1;
          ss_data_d  = STOP_CMD;
          tmo_flag_d = 1'b1;
        end
      end
      READOUT: begin
        if (dma_last_ok) begin
          captures_d = captures_inc;
          if ((repeat_q == '0) || (captures_inc < repeat_q)) state_d = ARM;
          else                                               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      repeat_q    <= '0;
      bank_q      <= '0;
      use_aux_q   <= 1'b0;
      captures_q  <= '0;
      tmo_flag_q  <= 1'b0;
      cfg_valid_q <= 1'b0;
      ss_valid_q  <= 1'b0;
      ss_data_q   <= 2'b00;
      trigger_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      repeat_q    <= repeat_d;
      bank_q      <= bank_d;
      use_aux_q   <= use_aux_d;
      captures_q  <= captures_d;
      tmo_flag_q  <= tmo_flag_d;
      cfg_valid_q <= cfg_valid_d;
      ss_valid_q  <= ss_valid_d;
      ss_data_q   <= ss_data_d;
      trigger_q   <= trigger_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_in.ready            = 1'b1;
  assign buffer_config.data      = bank_q;
  assign buffer_config.valid     = cfg_valid_q;
  assign buffer_config.last      = 1'b0;
  assign buffer_start_stop.data  = ss_data_q;
  assign buffer_start_stop.valid = ss_valid_q;
  assign buffer_start_stop.last  = 1'b0;
  assign trigger_out             = trigger_q;
  assign busy                    = busy_q;
  assign status = {state_q, tmo_flag_q, {(27-COUNT_W){1'b0}}, captures_q};
endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed self-checking bench for capture_sequencer
module tb_capture_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        capture_done, dma_last_ok, start_aux;
  logic        trigger_out, busy;
  logic [31:0] status;
  logic [3:0]  st;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axis_if #(.DATA_W(32)) cmd_if ();
  axis_if #(.DATA_W(2))  cfg_if ();
  axis_if #(.DATA_W(2))  ss_if ();

  capture_sequencer #(
    .BANK_W(2), .COUNT_W(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_in            (cmd_if.slave),
    .buffer_config     (cfg_if.master),
    .buffer_start_stop (ss_if.master),
    .capture_done      (capture_done),
    .dma_last_ok       (dma_last_ok),
    .start_aux         (start_aux),
    .trigger_out       (trigger_out),
    .busy              (busy),
    .status            (status)
  );

  assign st = status[31:28];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] d);
    cmd_if.data  = d;
    cmd_if.valid = 1'b1;
    step();
    cmd_if.valid = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (st != s && n < budget) begin
      step();
      n++;
    end
    check_vec(tag, {28'd0, st}, {28'd0, s});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_status"}, status, 32'd0);
    check_vec({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_vec({tag, "_trig"}, {31'd0, trigger_out}, 32'd0);
    check_vec({tag, "_cfg_valid"}, {31'd0, cfg_if.valid}, 32'd0);
    check_vec({tag, "_ss_valid"}, {31'd0, ss_if.valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cnt2, st_at_trig, prev;
    reset_n = 1'b0;
    capture_done = 1'b0; dma_last_ok = 1'b0; start_aux = 1'b0;
    cmd_if.data = '0; cmd_if.valid = 1'b0; cmd_if.last = 1'b0;
    cfg_if.ready = 1'b0; ss_if.ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst_in");
    reset_n = 1'b1;
    step();
    check_reset_outputs("rst_out");
    check_vec("cmd_ready", {31'd0, cmd_if.ready}, 32'd1);
    check_vec("last_tied", {30'd0, cfg_if.last, ss_if.last}, 32'd0);

    // repeat=1 bank=1 use_aux=0 arm
    send_cmd(32'h0001_0005);
    check_vec("t1_cfg_valid", {31'd0, cfg_if.valid}, 32'd1);
    check_vec("t1_cfg_data", {30'd0, cfg_if.data}, 32'd1);
    check_vec("t1_state_cfg", {28'd0, st}, 32'd1);
    check_vec("t1_busy", {31'd0, busy}, 32'd1);
    cfg_if.ready = 1'b1;
    step();
    check_vec("t1_state_arm", {28'd0, st}, 32'd2);
    check_vec("t1_cfg_dropped", {31'd0, cfg_if.valid}, 32'd0);
    step();
    check_vec("t1_start_valid", {31'd0, ss_if.valid}, 32'd1);
    check_vec("t1_start_data", {30'd0, ss_if.data}, 32'd2);
    step();
    check_vec("t1_state_capture", {28'd0, st}, 32'd4);
    capture_done = 1'b1; step(); capture_done = 1'b0;
    check_vec("t1_state_readout", {28'd0, st}, 32'd5);
    dma_last_ok = 1'b1; step(); dma_last_ok = 1'b0;
    check_vec("t1_final_status", status, 32'd1);
    check_vec("t1_final_busy", {31'd0, busy}, 32'd0);

    // use_aux with level already high before arm
    start_aux = 1'b1;
    step(); step();
    send_cmd(32'h0001_000B);
    check_vec("t2_cfg_data", {30'd0, cfg_if.data}, 32'd2);
    step(); step();
    check_vec("t2_state_wait", {28'd0, st}, 32'd3);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (trigger_out) cnt++;
      step();
    end
    check_vec("t2_no_trig_held", cnt, 0);
    check_vec("t2_still_wait", {28'd0, st}, 32'd3);
    start_aux = 1'b0;
    step(); step();
    start_aux = 1'b1;
    cnt = 0; st_at_trig = 15;
    for (int i = 0; i < 6; i++) begin
      step();
      if (trigger_out) begin
        cnt++;
        st_at_trig = int'(st);
      end
    end
    start_aux = 1'b0;
    check_vec("t2_trig_count", cnt, 1);
    check_vec("t2_trig_state", st_at_trig, 4);
    capture_done = 1'b1; step(); capture_done = 1'b0;
    dma_last_ok = 1'b1; step(); dma_last_ok = 1'b0;
    check_vec("t2_final_status", status, 32'd1);

    // repeat=3, bank=3, three capture/readout rounds
    send_cmd(32'h0003_000D);
    cnt = 0; cnt2 = 0; prev = 1;
    for (int i = 0; i < 80; i++) begin
      if (cfg_if.valid) cnt++;
      if (prev == 5 && st == 4'd2) cnt2++;
      if (st == 4'd0) break;
      prev = int'(st);
      capture_done = (st == 4'd4);
      dma_last_ok  = (st == 4'd5);
      step();
    end
    capture_done = 1'b0; dma_last_ok = 1'b0;
    check_vec("t3_cfg_sent", cnt, 1);
    check_vec("t3_arm_reentry", cnt2, 2);
    check_vec("t3_final_status", status, 32'd3);
    check_vec("t3_busy", {31'd0, busy}, 32'd0);

    // abort in CAPTURE with stop held off for 4 cycles
    send_cmd(32'h0000_0001);
    wait_state(4'd4, 20, "t4_reach_capture");
    ss_if.ready = 1'b0;
    send_cmd(32'h0000_0000);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (ss_if.valid && ss_if.data == 2'b01) cnt++;
      step();
    end
    if (ss_if.valid && ss_if.data == 2'b01) cnt++;
    ss_if.ready = 1'b1;
    step();
    check_vec("t4_stop_stable", cnt, 5);
    check_vec("t4_state_readout", {28'd0, st}, 32'd5);
    check_vec("t4_stop_dropped", {31'd0, ss_if.valid}, 32'd0);

    // abort in READOUT ignored; repeat=0 returns to ARM; abort in ARM goes IDLE
    send_cmd(32'h0000_0000);
    check_vec("t5_readout_abort", {28'd0, st}, 32'd5);
    dma_last_ok = 1'b1; step(); dma_last_ok = 1'b0;
    check_vec("t5_rearm", status, 32'h2000_0001);
    send_cmd(32'h0000_0000);
    check_vec("t5_arm_abort", {28'd0, st}, 32'd0);
    check_vec("t5_no_start", {31'd0, ss_if.valid}, 32'd0);
    dma_last_ok = 1'b1; step(); dma_last_ok = 1'b0;
    check_vec("t5_dma_idle_ignored", status, 32'd1);

    // capture_done and abort together
    send_cmd(32'h0001_0001);
    wait_state(4'd4, 20, "t6_reach_capture");
    capture_done = 1'b1;
    cmd_if.data = 32'h0; cmd_if.valid = 1'b1;
    step();
    capture_done = 1'b0; cmd_if.valid = 1'b0;
    check_vec("t6_state_readout", {28'd0, st}, 32'd5);
    cnt = int'(ss_if.valid);
    for (int i = 0; i < 3; i++) begin
      step();
      if (ss_if.valid) cnt++;
    end
    check_vec("t6_no_stop", cnt, 0);
    dma_last_ok = 1'b1; step(); dma_last_ok = 1'b0;
    check_vec("t6_idle", {28'd0, st}, 32'd0);

    // reset pulsed in WAIT_TRIG
    send_cmd(32'h0002_0003);
    wait_state(4'd3, 20, "t7_reach_wait");
    capture_done = 1'b1; step(); capture_done = 1'b0;
    check_vec("t7_done_ignored", {28'd0, st}, 32'd3);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t7_async");
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (ss_if.valid) cnt++;
    end
    check_vec("t7_no_stop", cnt, 0);
    reset_n = 1'b1;
    step();
    check_reset_outputs("t7_after");

`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
    send_cmd(32'h0001_0001);
    wait_state(4'd4, 20, "t8_reach_capture");
    cnt = 0;
    while (!ss_if.valid && cnt < 200) begin
      step();
      cnt++;
    end
    check_vec("t8_timeout_cycle", cnt, 100);
    check_vec("t8_stop_data", {30'd0, ss_if.data}, 32'd1);
    check_vec("t8_flag", {31'd0, status[27]}, 32'd1);
    step();
    check_vec("t8_state_readout", {28'd0, st}, 32'd5);
    dma_last_ok = 1'b1; step(); dma_last_ok = 1'b0;
    check_vec("t8_flag_sticky", status, 32'h0800_0001);
    send_cmd(32'h0001_0001);
    check_vec("t8_flag_cleared", {31'd0, status[27]}, 32'd0);
    send_cmd(32'h0000_0000);
    check_vec("t8_idle", {28'd0, st}, 32'd0);
`else
    send_cmd(32'h0001_0001);
    wait_state(4'd4, 20, "t8_reach_capture");
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (ss_if.valid) cnt++;
    end
    check_vec("t8_no_timeout_stop", cnt, 0);
    check_vec("t8_still_capture", {28'd0, st}, 32'd4);
    check_vec("t8_flag_zero", {31'd0, status[27]}, 32'd0);
    capture_done = 1'b1; step(); capture_done = 1'b0;
    dma_last_ok = 1'b1; step(); dma_last_ok = 1'b0;
    check_vec("t8_idle", status, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
